// File: rtl/id_exe_reg_pkg.sv
// Shared constants for the ID/EXE pipeline register.
// ALU opcodes, bubble values and default widths.
package id_exe_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic [3:0] EXE_ADD = 4'b0000;
    localparam logic [3:0] EXE_SUB = 4'b0010;
    localparam logic [3:0] EXE_AND = 4'b0100;
    localparam logic [3:0] EXE_OR  = 4'b0101;
    localparam logic [3:0] EXE_NOR = 4'b0110;
    localparam logic [3:0] EXE_XOR = 4'b0111;
    localparam logic [3:0] EXE_SLL = 4'b1000;
    localparam logic [3:0] EXE_SRA = 4'b1001;
    localparam logic [3:0] EXE_SRL = 4'b1010;

    // A bubble is an all-zero slot: ADD with nothing enabled.
    localparam logic [3:0] EXE_NOP = EXE_ADD;
    localparam logic       NOP_VALID = 1'b0;
    localparam logic       NOP_EN    = 1'b0;

endpackage

// File: rtl/id_exe_reg_sat_counter.sv
// Saturating up-counter with async reset and sync clear.
// Clear takes priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;
    assign cnt    = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush-to-bubble
// and saturating stall/kill performance counters.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val1_in,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic [REG_AW-1:0] dest_in,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [3:0]        exe_cmd_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val1_out,
    output logic [DATA_W-1:0] val2_out,
    output logic [DATA_W-1:0] st_val_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    logic              r_valid;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_mem_w_en;
    logic [3:0]        r_exe_cmd;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;
    logic [DATA_W-1:0] r_st_val;
    logic [REG_AW-1:0] r_src1;
    logic [REG_AW-1:0] r_src2;
    logic [REG_AW-1:0] r_dest;

    logic w_stall_inc;
    logic w_kill_inc;

    assign w_stall_inc = freeze && !flush;
    assign w_kill_inc  = flush && r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= NOP_VALID;
            r_wb_en    <= NOP_EN;
            r_mem_r_en <= NOP_EN;
            r_mem_w_en <= NOP_EN;
            r_exe_cmd  <= EXE_NOP;
            r_pc       <= '0;
            r_val1     <= '0;
            r_val2     <= '0;
            r_st_val   <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_dest     <= '0;
        end else if (flush) begin
            r_valid    <= NOP_VALID;
            r_wb_en    <= NOP_EN;
            r_mem_r_en <= NOP_EN;
            r_mem_w_en <= NOP_EN;
            r_exe_cmd  <= EXE_NOP;
            r_pc       <= '0;
            r_val1     <= '0;
            r_val2     <= '0;
            r_st_val   <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_dest     <= '0;
        end else if (!freeze) begin
            // Enables are masked so a non-valid slot never writes anything.
            r_valid    <= valid_in;
            r_wb_en    <= valid_in && wb_en_in;
            r_mem_r_en <= valid_in && mem_r_en_in;
            r_mem_w_en <= valid_in && mem_w_en_in;
            r_exe_cmd  <= exe_cmd_in;
            r_pc       <= pc_in;
            r_val1     <= val1_in;
            r_val2     <= val2_in;
            r_st_val   <= st_val_in;
            r_src1     <= src1_in;
            r_src2     <= src2_in;
            r_dest     <= dest_in;
        end
    end

    assign valid_out    = r_valid;
    assign wb_en_out    = r_wb_en;
    assign mem_r_en_out = r_mem_r_en;
    assign mem_w_en_out = r_mem_w_en;
    assign exe_cmd_out  = r_exe_cmd;
    assign pc_out       = r_pc;
    assign val1_out     = r_val1;
    assign val2_out     = r_val2;
    assign st_val_out   = r_st_val;
    assign src1_out     = r_src1;
    assign src2_out     = r_src2;
    assign dest_out     = r_dest;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_kill_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_kill_inc),
        .cnt (kill_cnt)
    );

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
Pipeline register between the ID stage and the EXE stage, which contains the ALU. Each cycle it latches decoded control, operands and register indices, and presents them to the ALU, the forwarding logic and the EXE/MEM register.
- freeze: holds the current contents while downstream is stalled.
- flush: inserts a bubble, for a taken branch or a load-use hazard.
- Two saturating performance counters record stall cycles and killed instructions.

Parameters:
DATA_W, 32, width of operands and PC
REG_AW, 5, register-file index width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  hold all pipeline fields this cycle
flush  in  1  replace contents with a bubble this cycle
clr_cnt  in  1  synchronous clear of both counters
valid_in  in  1  ID slot holds a real instruction
wb_en_in  in  1  register write-back enable
mem_r_en_in  in  1  load
mem_w_en_in  in  1  store
exe_cmd_in  in  4  ALU opcode
pc_in  in  DATA_W  PC+4 of the instruction
val1_in  in  DATA_W  ALU operand 1
val2_in  in  DATA_W  ALU operand 2 (register or immediate)
st_val_in  in  DATA_W  store data (rt value)
src1_in  in  REG_AW  rs index, for forwarding
src2_in  in  REG_AW  rt index, for forwarding
dest_in  in  REG_AW  destination index
valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out, pc_out, val1_out, val2_out, st_val_out, src1_out, src2_out, dest_out  out  (same widths as inputs)  registered copies
stall_cnt  out  CNT_W  cycles spent frozen
kill_cnt  out  CNT_W  valid instructions removed by flush

Behaviour:
- Reset (async, rst=1): every output is 0 immediately, including both counters. This means exe_cmd_out=ADD (4'b0000) and valid=0, i.e. a bubble.
- Per-edge priority for the pipeline fields is flush > freeze > load:
  - flush=1: all fields become 0, the bubble value. This applies even if freeze=1.
  - freeze=1, flush=0: all fields hold.
  - Otherwise: all fields load from the *_in ports.
- Latency: one cycle from inputs to outputs. There is no combinational path from any input to any output.
- Bubble invariant: valid_out=0 implies wb_en_out=mem_r_en_out=mem_w_en_out=0.
- Fields are loaded with that invariant enforced: if valid_in=0, all three enables load as 0 regardless of their inputs.
- stall_cnt:
  - Increments when freeze=1 and flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
- kill_cnt:
  - Increments when flush=1 and the register currently holds valid_out=1. Flushing a bubble does not count.
  - Saturates at 2^CNT_W-1.
- clr_cnt=1: both counters go to 0 on that edge. It overrides any increment in the same cycle and has no effect on the pipeline fields.
- rst asserted mid-operation clears state immediately. The first edge after deassertion behaves as a normal load.
- exe_cmd is passed through unchecked. Undefined codes are carried as-is.

Decomposition:
- Shared package:
  - EXE_CMD constants: ADD=0000, SUB=0010, AND=0100, OR=0101, NOR=0110, XOR=0111, SLL=1000, SRA=1001, SRL=1010.
  - NOP/bubble constants.
  - DATA_W/REG_AW defaults.
- Sub-module sat_counter: parameter W; ports clk, rst, clr, inc, cnt. Instantiated twice.

Test Plan:
- Reset: drive random inputs with rst=1, then release. All outputs are 0 during reset. First edge with valid_in=1, exe_cmd_in=SUB, val1=7, val2=3 gives those values on the outputs one cycle later.
- Freeze: load dest=5, val1=0x10, then freeze=1 for 3 cycles with changed inputs. Outputs hold dest=5, val1=0x10; stall_cnt=3. First edge after release loads the new inputs.
- Flush vs freeze: a valid load instruction (mem_r_en=1) is held; assert flush=1 and freeze=1 together. Next cycle valid_out=0 with all enables 0, kill_cnt=1, stall_cnt unchanged.
- Flush of a bubble: second consecutive flush leaves kill_cnt=1. valid_in=0 with wb_en_in=1 loads wb_en_out=0.
- Counter saturation/clear: CNT_W=4, freeze held 20 cycles gives stall_cnt=15. clr_cnt=1 together with freeze=1 gives stall_cnt=0 on that edge, then 1 on the next.
- Async reset mid-freeze: assert rst between edges while frozen with valid_out=1. Outputs go to 0 before the next edge, and both counters read 0.
